// File: rtl/score_submitter.sv
// rtl/score_submitter.sv - play-round score accumulator that submits to a score tracker and waits for its verdict
// A login opens a timed round; hits are counted, the score is submitted once, then the tracker reply (or a timeout) is latched.
module score_submitter #(
    parameter int ROUND_CYCLES = 1000,
    parameter int MAX_SCORE    = 100,
    parameter int TIMEOUT      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       login,
    input  logic [2:0] player_id_in,
    input  logic       guest_in,
    input  logic       hit,
    output logic       score_req,
    output logic [6:0] score,
    output logic [2:0] playerID,
    output logic       isGuest,
    input  logic       valid,
    input  logic       personal_winner,
    input  logic       global_winner,
    output logic       busy,
    output logic       done,
    output logic       pw_flag,
    output logic       gw_flag,
    output logic       err_timeout
);

    localparam int TW = $clog2(ROUND_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(ROUND_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LOAD  = WW'(TIMEOUT);
    localparam logic [6:0]    SCORE_CAP  = 7'(MAX_SCORE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_SUBMIT,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [6:0]    score_q, score_d;
    logic [2:0]    player_id_q, player_id_d;
    logic          is_guest_q, is_guest_d;
    logic          pw_q, pw_d;
    logic          gw_q, gw_d;
    logic          err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            wait_q      <= '0;
            score_q     <= '0;
            player_id_q <= '0;
            is_guest_q  <= 1'b0;
            pw_q        <= 1'b0;
            gw_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            wait_q      <= wait_d;
            score_q     <= score_d;
            player_id_q <= player_id_d;
            is_guest_q  <= is_guest_d;
            pw_q        <= pw_d;
            gw_q        <= gw_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        wait_d      = wait_q;
        score_d     = score_q;
        player_id_d = player_id_q;
        is_guest_d  = is_guest_q;
        pw_d        = pw_q;
        gw_d        = gw_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_RESULT: begin
                if (login) begin
                    player_id_d = player_id_in;
                    is_guest_d  = guest_in;
                    score_d     = '0;
                    timer_d     = TIMER_LOAD;
                    pw_d        = 1'b0;
                    gw_d        = 1'b0;
                    err_d       = 1'b0;
                    state_d     = S_PLAY;
                end
            end
            S_PLAY: begin
                // The hit in the timer==0 cycle still counts: scoring is independent of the exit test.
                if (hit && (score_q < SCORE_CAP)) begin
                    score_d = score_q + 7'd1;
                end
                if (timer_q == '0) begin
                    state_d = S_SUBMIT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_SUBMIT: begin
                wait_d  = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (valid) begin
                    pw_d    = personal_winner;
                    gw_d    = global_winner;
                    err_d   = 1'b0;
                    wait_d  = '0;
                    state_d = S_RESULT;
                end else if (wait_q <= WW'(1)) begin
                    err_d   = 1'b1;
                    wait_d  = '0;
                    state_d = S_RESULT;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign score_req   = (state_q == S_SUBMIT);
    assign busy        = (state_q == S_PLAY) || (state_q == S_SUBMIT) || (state_q == S_WAIT);
    assign done        = (state_q == S_RESULT);
    assign score       = score_q;
    assign playerID    = player_id_q;
    assign isGuest     = is_guest_q;
    assign pw_flag     = pw_q;
    assign gw_flag     = gw_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_score_submitter.sv
// tb/tb_score_submitter.sv - directed self-checking bench for score_submitter
module tb_score_submitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       login = 1'b0;
    logic [2:0] player_id_in = 3'd0;
    logic       guest_in = 1'b0;
    logic       hit = 1'b0;
    logic       valid = 1'b0;
    logic       personal_winner = 1'b0;
    logic       global_winner = 1'b0;

    logic       score_req_a, is_guest_a, busy_a, done_a, pw_a, gw_a, err_a;
    logic [6:0] score_a;
    logic [2:0] pid_a;
    logic       score_req_b, is_guest_b, busy_b, done_b, pw_b, gw_b, err_b;
    logic [6:0] score_b;
    logic [2:0] pid_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    score_submitter #(.ROUND_CYCLES(8), .MAX_SCORE(100), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .login(login), .player_id_in(player_id_in), .guest_in(guest_in),
        .hit(hit), .score_req(score_req_a), .score(score_a), .playerID(pid_a), .isGuest(is_guest_a),
        .valid(valid), .personal_winner(personal_winner), .global_winner(global_winner),
        .busy(busy_a), .done(done_a), .pw_flag(pw_a), .gw_flag(gw_a), .err_timeout(err_a)
    );

    score_submitter #(.ROUND_CYCLES(200), .MAX_SCORE(100), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .login(login), .player_id_in(player_id_in), .guest_in(guest_in),
        .hit(hit), .score_req(score_req_b), .score(score_b), .playerID(pid_b), .isGuest(is_guest_b),
        .valid(valid), .personal_winner(personal_winner), .global_winner(global_winner),
        .busy(busy_b), .done(done_b), .pw_flag(pw_b), .gw_flag(gw_b), .err_timeout(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [2:0] id, input logic g);
        player_id_in = id;
        guest_in     = g;
        login        = 1'b1;
        tick();
        login        = 1'b0;
    endtask

    // Returns the number of cycles after the login edge at which score_req was seen (0 = never).
    task automatic wait_submit(input int nhits, output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            hit = (i <= nhits);
            tick();
            if (score_req_a) begin
                cyc = i;
                break;
            end
        end
        hit = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({score_req_a, score_a, pid_a, is_guest_a, busy_a, done_a, pw_a, gw_a, err_a} !== 16'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {score_req_a, score_a, pid_a, is_guest_a, busy_a, done_a, pw_a, gw_a, err_a});
        end
    endtask

    task automatic test_round();
        int cyc;
        start_round(3'd5, 1'b0);
        checks++;
        if ({busy_a, score_a, pid_a} !== {1'b1, 7'd0, 3'd5}) begin
            failures++;
            $display("FAIL round_start got busy=%b score=%0d id=%0d exp busy=1 score=0 id=5", busy_a, score_a, pid_a);
        end
        wait_submit(3, cyc);
        checks++;
        if (cyc !== 8) begin
            failures++;
            $display("FAIL round_latency got=%0d exp=8", cyc);
        end
        checks++;
        if ({score_a, pid_a, is_guest_a} !== {7'd3, 3'd5, 1'b0}) begin
            failures++;
            $display("FAIL round_submit got score=%0d id=%0d guest=%b exp 3 5 0", score_a, pid_a, is_guest_a);
        end
        tick();
        checks++;
        if ({score_req_a, busy_a} !== 2'b01) begin
            failures++;
            $display("FAIL req_one_cycle got req=%b busy=%b exp req=0 busy=1", score_req_a, busy_a);
        end
    endtask

    // Entered while observing the first WAIT cycle.
    task automatic test_response();
        tick();
        tick();
        valid = 1'b1; personal_winner = 1'b1; global_winner = 1'b0;
        tick();
        valid = 1'b0; personal_winner = 1'b0;
        checks++;
        if ({done_a, busy_a, pw_a, gw_a, err_a, score_a} !== {5'b10100, 7'd3}) begin
            failures++;
            $display("FAIL response got done=%b busy=%b pw=%b gw=%b err=%b score=%0d exp 1 0 1 0 0 3",
                     done_a, busy_a, pw_a, gw_a, err_a, score_a);
        end
        hit = 1'b1;
        tick();
        hit = 1'b0;
        checks++;
        if ({done_a, pw_a, score_a} !== {2'b11, 7'd3}) begin
            failures++;
            $display("FAIL result_hold got done=%b pw=%b score=%0d exp 1 1 3", done_a, pw_a, score_a);
        end
    endtask

    task automatic test_relogin_and_timeout();
        int cyc;
        start_round(3'd2, 1'b1);
        checks++;
        if ({busy_a, done_a, pid_a, is_guest_a, score_a, pw_a, gw_a, err_a} !== {2'b10, 3'd2, 1'b1, 7'd0, 3'b000}) begin
            failures++;
            $display("FAIL relogin got busy=%b done=%b id=%0d guest=%b score=%0d pw=%b gw=%b err=%b",
                     busy_a, done_a, pid_a, is_guest_a, score_a, pw_a, gw_a, err_a);
        end
        tick();
        tick();
        player_id_in = 3'd7; guest_in = 1'b0; login = 1'b1;
        tick();
        login = 1'b0;
        checks++;
        if ({pid_a, is_guest_a} !== {3'd2, 1'b1}) begin
            failures++;
            $display("FAIL midplay_login_id got id=%0d guest=%b exp 2 1", pid_a, is_guest_a);
        end
        wait_submit(0, cyc);
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("FAIL midplay_no_restart got=%0d exp=5", cyc);
        end
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done_a) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc !== 5) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=5", cyc);
        end
        checks++;
        if ({err_a, pw_a, gw_a} !== 3'b100) begin
            failures++;
            $display("FAIL timeout_flags got err=%b pw=%b gw=%b exp 1 0 0", err_a, pw_a, gw_a);
        end
    endtask

    task automatic test_expiry_valid();
        int cyc;
        start_round(3'd1, 1'b0);
        wait_submit(2, cyc);
        repeat (4) tick();
        valid = 1'b1; global_winner = 1'b1;
        tick();
        valid = 1'b0; global_winner = 1'b0;
        checks++;
        if ({done_a, err_a, pw_a, gw_a, score_a} !== {4'b1001, 7'd2}) begin
            failures++;
            $display("FAIL expiry_valid got done=%b err=%b pw=%b gw=%b score=%0d exp 1 0 0 1 2",
                     done_a, err_a, pw_a, gw_a, score_a);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_round(3'd3, 1'b1);
        hit = 1'b1;
        repeat (3) tick();
        hit = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({score_req_a, score_a, pid_a, is_guest_a, busy_a, done_a, pw_a, gw_a, err_a} !== 16'd0) begin
            failures++;
            $display("FAIL reset_midplay got=%h exp=0", {score_req_a, score_a, pid_a, is_guest_a, busy_a, done_a, pw_a, gw_a, err_a});
        end
        start_round(3'd4, 1'b0);
        wait_submit(0, cyc);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid = 1'b1; personal_winner = 1'b1; global_winner = 1'b1;
        tick();
        valid = 1'b0; personal_winner = 1'b0; global_winner = 1'b0;
        checks++;
        if ({busy_a, done_a, pw_a, gw_a, err_a, pid_a} !== 8'd0) begin
            failures++;
            $display("FAIL late_valid_ignored got busy=%b done=%b pw=%b gw=%b err=%b id=%0d exp all 0",
                     busy_a, done_a, pw_a, gw_a, err_a, pid_a);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start_round(3'd6, 1'b0);
        hit = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (score_req_b) begin
                cyc = i;
                break;
            end
        end
        hit = 1'b0;
        checks++;
        if (cyc !== 200) begin
            failures++;
            $display("FAIL sat_latency got=%0d exp=200", cyc);
        end
        checks++;
        if (score_b !== 7'd100) begin
            failures++;
            $display("FAIL saturation got=%0d exp=100", score_b);
        end
    endtask

    initial begin
        test_reset();
        test_round();
        test_response();
        test_relogin_and_timeout();
        test_expiry_valid();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_submitter.md
SCORE_SUBMITTER -- requirements
Module: score_submitter

Interface
REQ-001 SHALL have parameter ROUND_CYCLES, default 1000: number of clk cycles in one play round (>=1).
REQ-002 SHALL have parameter MAX_SCORE, default 100: saturation ceiling for the round score (<=127).
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum number of WAIT cycles allowed for a tracker response (>=1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port login, input, 1 bit: one-cycle pulse that starts a session.
REQ-007 SHALL have port player_id_in, input, 3 bits: player identity, sampled on login.
REQ-008 SHALL have port guest_in, input, 1 bit: guest flag, sampled on login.
REQ-009 SHALL have port hit, input, 1 bit: +1 point per cycle when asserted during PLAY.
REQ-010 SHALL have port score_req, output, 1 bit: submit strobe to the score tracker.
REQ-011 SHALL have port score, output, 7 bits: round score presented to the tracker.
REQ-012 SHALL have port playerID, output, 3 bits: latched player identity.
REQ-013 SHALL have port isGuest, output, 1 bit: latched guest flag.
REQ-014 SHALL have port valid, input, 1 bit: tracker response strobe.
REQ-015 SHALL have port personal_winner, input, 1 bit: tracker result, meaningful only when valid=1.
REQ-016 SHALL have port global_winner, input, 1 bit: tracker result, meaningful only when valid=1.
REQ-017 SHALL have port busy, output, 1 bit: 1 in PLAY, SUBMIT and WAIT.
REQ-018 SHALL have port done, output, 1 bit: 1 in RESULT.
REQ-019 SHALL have port pw_flag, output, 1 bit: latched personal_winner.
REQ-020 SHALL have port gw_flag, output, 1 bit: latched global_winner.
REQ-021 SHALL have port err_timeout, output, 1 bit: 1 in RESULT if no valid response arrived.

Function
REQ-022 SHALL implement the FSM states IDLE, PLAY, SUBMIT, WAIT and RESULT.
REQ-023 SHALL, in IDLE or RESULT on login=1, latch playerID and isGuest, set score=0, load the round timer with ROUND_CYCLES-1, clear pw_flag, gw_flag and err_timeout, and go to PLAY.
REQ-024 SHALL, in PLAY, increment score by 1 on each cycle with hit=1, saturating at MAX_SCORE (no wrap).
REQ-025 SHALL, in PLAY, decrement the timer every cycle and go to SUBMIT on the cycle the timer reads 0; a hit in that final cycle SHALL be counted.
REQ-026 SHALL give PLAY a length of exactly ROUND_CYCLES cycles.
REQ-027 SHALL ignore login in PLAY, SUBMIT and WAIT (no restart, no relatch).
REQ-028 SHALL ignore hit outside PLAY.
REQ-029 SHALL, in SUBMIT, assert score_req=1 for exactly that one cycle, load the wait counter with TIMEOUT, and go to WAIT.
REQ-030 SHALL hold score, playerID and isGuest stable from SUBMIT entry until RESULT exit.
REQ-031 SHALL sample valid only in WAIT; valid in any other state SHALL be ignored.
REQ-032 SHALL, in WAIT with valid=1, latch personal_winner into pw_flag and global_winner into gw_flag, keep err_timeout=0, and go to RESULT.
REQ-033 SHALL, in WAIT with valid=0, decrement the wait counter; on the cycle it reads 1, set err_timeout=1, leave pw_flag=gw_flag=0, and go to RESULT, so WAIT lasts at most TIMEOUT cycles.
REQ-034 SHALL give valid=1 priority over timeout when both occur in the same cycle.
REQ-035 SHALL hold all flags in RESULT until the next login.

Reset
REQ-036 SHALL, while rst=1 on a clock edge, force IDLE with score_req, score, playerID, isGuest, busy, done, pw_flag, gw_flag and err_timeout all 0, and clear both counters.
REQ-037 SHALL let rst take priority over every other input, including mid-PLAY and mid-WAIT; a response arriving after reset SHALL be ignored.

Verification
REQ-038 SHALL pass this scenario (ROUND_CYCLES=8): login with id=5 and guest=0, hit on 3 cycles -> score_req pulses once, exactly 8 cycles after the login edge, with score=3, playerID=5, isGuest=0.
REQ-039 SHALL pass this scenario (ROUND_CYCLES=200, MAX_SCORE=100): hit held high all round -> score=100 at SUBMIT, no wrap.
REQ-040 SHALL pass this scenario: valid=1 with personal_winner=1 and global_winner=0 on the 3rd WAIT cycle -> next cycle done=1, pw_flag=1, gw_flag=0, err_timeout=0.
REQ-041 SHALL pass this scenario (TIMEOUT=4): no valid -> RESULT after 4 WAIT cycles with err_timeout=1; valid on the exact expiry cycle -> err_timeout=0.
REQ-042 SHALL pass this scenario: rst mid-PLAY, or login mid-PLAY -> reset forces IDLE with all outputs 0; the mid-PLAY login is ignored and playerID is unchanged.
REQ-043 SHALL pass this scenario: login in RESULT with id=2 and guest=1 -> flags clear and PLAY starts with playerID=2, isGuest=1, score=0.
